r_cpu_ctrl: RTL and testbench
=============================

Name: r_cpu_ctrl

Overview:
- Multi-cycle sequencer for the R-type CPU.
- Fetches a 32-bit instruction, decodes MIPS R-type funct into the 4-bit ALU operation code, and drives register-file addresses and write enables.
- Latches ALU status flags on writeback and halts on illegal encodings.
- Sits between instruction memory, register file and the ALU. It owns the PC and the instruction register.

Parameters:
- PC_W, 8, PC width in bits; PC is a byte address that advances by 4 and wraps modulo 2^PC_W.
- CNT_W, 16, retired-instruction counter width; the counter wraps.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary.
- inst  in  32  instruction memory read data for the current pc (combinational read).
- pc  out  PC_W  current fetch address.
- rs_addr  out  5  register file read port A address, = IR[25:21].
- rt_addr  out  5  register file read port B address, = IR[20:16].
- rd_addr  out  5  register file write address, = IR[15:11].
- reg_we  out  1  register file write enable, single-cycle pulse.
- alu_op  out  4  operation code to the ALU.
- zf_i, of_i, sf_i, cf_i, pf_i  in  1 each  ALU status flags.
- flags  out  5  latched {ZF,OF,SF,CF,PF}.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an illegal instruction is decoded.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-instruction):
  - pc=0, IR=0, alu_op=4'b0000, flags=0, reg_we=0, illegal=0, retired=0, state=IDLE.
  - busy=0, halted=0.
- States are IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: goes to FETCH when run=1, else stays. All strobes low.
- FETCH: IR<=inst; pc<=pc+4, wrapping at 2^PC_W. Next state is DECODE.
- DECODE: classifies IR.
  - Legal means IR[31:26]==6'b000000 and funct IR[5:0] is in the map below.
  - Legal: alu_op register loaded from the map; next state is EXEC.
  - Illegal: illegal<=1, alu_op unchanged; next state is HALT.
  - Funct map:
    - 100100 AND -> 0000
    - 100101 OR -> 0001
    - 100110 XOR -> 0010
    - 100111 NOR -> 0011
    - 100000 ADD -> 0100
    - 100010 SUB -> 0101
    - 101011 SLTU -> 0110
    - 000100 SLLV -> 0111
  - Every other funct is illegal, including 000000, so an all-zero word halts.
- EXEC: alu_op and rs/rt addresses are stable for one full cycle so the ALU result settles. Next state is WB.
- WB:
  - reg_we=1 for exactly this cycle, unless rd_addr==0, in which case reg_we=0.
  - flags<={zf_i,of_i,sf_i,cf_i,pf_i} is latched at the end of WB, including when rd==0.
  - retired<=retired+1, wrapping.
  - Next state is FETCH if run=1, else IDLE.
- HALT: absorbing. Only rst exits it. pc, flags and retired are frozen; reg_we=0.
- Throughput is exactly 4 cycles per legal instruction (FETCH, DECODE, EXEC, WB). The first fetch occurs on the cycle after run is seen high in IDLE.
- run deassertion mid-instruction: the current instruction completes through WB, then the block enters IDLE. run is sampled only in IDLE and WB.
- rs/rt/rd_addr are combinational from IR and valid from DECODE onward.
- alu_op is registered, valid from EXEC through the following DECODE, and unchanged when an illegal instruction is decoded.
- flags are unchanged except at WB.
- pc wrap: at pc = 2^PC_W-4, FETCH sets pc=0 with no error.

Test Plan:
- Reset then run=1, inst=0x01095020 (ADD rd=10, rs=8, rt=9):
  - FETCH at cycle 1; alu_op=0100 in EXEC (cycle 3); reg_we=1 with rd_addr=10 in cycle 4.
  - retired=1, pc=4; next FETCH at cycle 5.
- Sequence AND, OR, XOR, NOR, SUB, SLTU, SLLV (funct 24, 25, 26, 27, 22, 2B, 04):
  - alu_op is 0000, 0001, 0010, 0011, 0101, 0110, 0111 in the respective EXEC cycles.
  - After 7 instructions, retired=7 and pc=28.
- SUB with rd=0, zf_i=1 driven in WB:
  - reg_we stays 0; flags=5'b10000 after WB; retired increments.
- inst=0x8C000000 (opcode 100011):
  - illegal=1 and halted=1 after DECODE; pc=4; busy=0.
  - Further run has no effect; rst clears to IDLE with pc=0.
- run dropped in EXEC:
  - WB still pulses reg_we; state goes to IDLE; pc holds.
  - Re-asserting run resumes FETCH at the next pc.
- Wrap and async reset:
  - With PC_W=4, execute 4 instructions; pc returns to 0.
  - Asserting rst mid-EXEC, asynchronously between clock edges, immediately clears pc, alu_op, flags and reg_we.

Source files
------------

// File: rtl/r_cpu_ctrl.sv
// Multi-cycle sequencer for the R-type CPU: fetch, decode of the funct field into an
// ALU op code, register-file addressing/write strobe, flag capture and illegal halt.
module r_cpu_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      inst,
  output logic [PC_W-1:0]  pc,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic             reg_we,
  output logic [3:0]       alu_op,
  input  logic             zf_i,
  input  logic             of_i,
  input  logic             sf_i,
  input  logic             cf_i,
  input  logic             pf_i,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  logic        dec_legal;
  logic [3:0]  dec_op;

  // The shamt field has no role in this instruction subset.
  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];

  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];
  assign rd_addr = ir[15:11];

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'b0000;
    if (ir[31:26] == 6'b000000) begin
      dec_legal = 1'b1;
      case (ir[5:0])
        6'b100100: dec_op = 4'b0000;
        6'b100101: dec_op = 4'b0001;
        6'b100110: dec_op = 4'b0010;
        6'b100111: dec_op = 4'b0011;
        6'b100000: dec_op = 4'b0100;
        6'b100010: dec_op = 4'b0101;
        6'b101011: dec_op = 4'b0110;
        6'b000100: dec_op = 4'b0111;
        default:   dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = FETCH;
      FETCH:   state_nx = DECODE;
      DECODE:  state_nx = dec_legal ? EXEC : HALT;
      EXEC:    state_nx = WB;
      WB:      state_nx = run ? FETCH : IDLE;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      alu_op  <= 4'b0000;
      flags   <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH: begin
          ir <= inst;
          pc <= pc + PC_W'(4);
        end
        DECODE: begin
          if (dec_legal) alu_op  <= dec_op;
          else           illegal <= 1'b1;
        end
        WB: begin
          flags   <= {zf_i, of_i, sf_i, cf_i, pf_i};
          retired <= retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Writes to register 0 are suppressed; flags still update in that case.
  assign reg_we = (state == WB) && (rd_addr != 5'd0);
  assign busy   = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_r_cpu_ctrl.sv
// Randomized self-checking bench for r_cpu_ctrl against an instruction-level reference model.
module tb_r_cpu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] inst = '0;
  logic        zf_i = 1'b0, of_i = 1'b0, sf_i = 1'b0, cf_i = 1'b0, pf_i = 1'b0;

  logic [7:0]  pc;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        reg_we, busy, halted, illegal;
  logic [3:0]  alu_op;
  logic [4:0]  flags;
  logic [15:0] retired;

  logic [3:0]  pc4;
  logic [4:0]  d4_rs, d4_rt, d4_rd, d4_flags;
  logic        d4_we, d4_busy, d4_halted, d4_illegal;
  logic [3:0]  d4_op;
  logic [15:0] d4_retired;

  r_cpu_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .pc(pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .reg_we(reg_we),
    .alu_op(alu_op), .zf_i(zf_i), .of_i(of_i), .sf_i(sf_i), .cf_i(cf_i), .pf_i(pf_i),
    .flags(flags), .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  r_cpu_ctrl #(.PC_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .pc(pc4),
    .rs_addr(d4_rs), .rt_addr(d4_rt), .rd_addr(d4_rd), .reg_we(d4_we),
    .alu_op(d4_op), .zf_i(zf_i), .of_i(of_i), .sf_i(sf_i), .cf_i(cf_i), .pf_i(pf_i),
    .flags(d4_flags), .busy(d4_busy), .halted(d4_halted), .illegal(d4_illegal), .retired(d4_retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, tracked per instruction
  logic [7:0]  m_pc;
  logic [3:0]  m_op;
  logic [4:0]  m_flags;
  logic [15:0] m_ret;

  // op code i is the ALU operation for funct_tbl[i]
  logic [5:0] funct_tbl [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};

  function automatic void ref_op(input logic [31:0] w, output bit legal, output logic [3:0] op);
    legal = 1'b0;
    op    = 4'b0000;
    if (w[31:26] == 6'd0)
      for (int i = 0; i < 8; i++)
        if (w[5:0] == funct_tbl[i]) begin
          legal = 1'b1;
          op    = 4'(i);
        end
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] rand_legal(input bit allow_rd0);
    logic [4:0] rd;
    rd = 5'($urandom);
    if (!allow_rd0 && rd == 5'd0) rd = 5'd1;
    return mk_r(5'($urandom), 5'($urandom), rd, funct_tbl[$urandom_range(0, 7)]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_pc = '0; m_op = '0; m_flags = '0; m_ret = '0;
  endtask

  // Leaves IDLE: expects busy low before, FETCH after the next edge.
  task automatic go();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    run = 1'b1;
    tick();
  endtask

  // Called with the DUT in FETCH; walks one instruction through to the next boundary.
  task automatic exec_instr(input logic [31:0] w, input logic [4:0] fin, input bit run_after);
    bit legal;
    logic [3:0] op;
    ref_op(w, legal, op);
    inst = w;
    vectors += 4;
    if (busy !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL fetch_state: busy=%b halted=%b want 1/0", busy, halted); end
    if (pc !== m_pc) begin miscompares++; $display("FAIL fetch_pc: got %h want %h", pc, m_pc); end
    if (pc4 !== m_pc[3:0]) begin miscompares++; $display("FAIL fetch_pc4: got %h want %h", pc4, m_pc[3:0]); end
    if (retired !== m_ret) begin miscompares++; $display("FAIL fetch_retired: got %0d want %0d", retired, m_ret); end
    tick();
    m_pc = m_pc + 8'd4;
    vectors += 5;
    if (pc !== m_pc) begin miscompares++; $display("FAIL decode_pc: got %h want %h", pc, m_pc); end
    if (pc4 !== m_pc[3:0]) begin miscompares++; $display("FAIL decode_pc4: got %h want %h", pc4, m_pc[3:0]); end
    if ({rs_addr, rt_addr, rd_addr} !== {w[25:21], w[20:16], w[15:11]}) begin
      miscompares++; $display("FAIL decode_addr: got %0d/%0d/%0d want %0d/%0d/%0d",
        rs_addr, rt_addr, rd_addr, w[25:21], w[20:16], w[15:11]); end
    if (alu_op !== m_op) begin miscompares++; $display("FAIL decode_aluop_hold: got %b want %b", alu_op, m_op); end
    if (reg_we !== 1'b0) begin miscompares++; $display("FAIL decode_we: got %b want 0", reg_we); end
    tick();
    if (!legal) begin
      vectors += 3;
      if ({halted, busy, illegal} !== 3'b101) begin miscompares++; $display("FAIL halt_state: halted/busy/illegal=%b want 101", {halted, busy, illegal}); end
      if (alu_op !== m_op) begin miscompares++; $display("FAIL halt_aluop: got %b want %b", alu_op, m_op); end
      if (pc !== m_pc) begin miscompares++; $display("FAIL halt_pc: got %h want %h", pc, m_pc); end
      return;
    end
    m_op = op;
    vectors += 3;
    if (alu_op !== m_op) begin miscompares++; $display("FAIL exec_aluop: got %b want %b", alu_op, m_op); end
    if (reg_we !== 1'b0) begin miscompares++; $display("FAIL exec_we: got %b want 0", reg_we); end
    if (flags !== m_flags) begin miscompares++; $display("FAIL exec_flags: got %b want %b", flags, m_flags); end
    {zf_i, of_i, sf_i, cf_i, pf_i} = fin;
    run = run_after;
    tick();
    vectors += 3;
    if (reg_we !== (w[15:11] != 5'd0)) begin miscompares++; $display("FAIL wb_we: got %b want %b (rd=%0d)", reg_we, w[15:11] != 5'd0, w[15:11]); end
    if (flags !== m_flags) begin miscompares++; $display("FAIL wb_flags_hold: got %b want %b", flags, m_flags); end
    if (alu_op !== m_op) begin miscompares++; $display("FAIL wb_aluop: got %b want %b", alu_op, m_op); end
    tick();
    m_ret   = m_ret + 16'd1;
    m_flags = fin;
    vectors += 4;
    if (retired !== m_ret) begin miscompares++; $display("FAIL post_retired: got %0d want %0d", retired, m_ret); end
    if (flags !== m_flags) begin miscompares++; $display("FAIL post_flags: got %b want %b", flags, m_flags); end
    if (busy !== run_after) begin miscompares++; $display("FAIL post_busy: got %b want %b", busy, run_after); end
    if (pc !== m_pc) begin miscompares++; $display("FAIL post_pc: got %h want %h", pc, m_pc); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_pc = '0; m_op = '0; m_flags = '0; m_ret = '0;
    for (int c = 0; c < 3; c++) begin
      vectors += 2;
      if ({pc, alu_op, flags, retired} !== '0) begin
        miscompares++; $display("FAIL reset_regs: pc=%h op=%b flags=%b ret=%0d want all 0", pc, alu_op, flags, retired); end
      if ({reg_we, illegal, busy, halted} !== 4'b0000) begin
        miscompares++; $display("FAIL reset_strobes: we/ill/busy/halt=%b want 0000", {reg_we, illegal, busy, halted}); end
      tick();
    end
  endtask

  task automatic test_add();
    go();
    exec_instr(32'h01095020, 5'($urandom), 1'b1);
    vectors += 2;
    if (alu_op !== 4'b0100) begin miscompares++; $display("FAIL add_aluop: got %b want 0100", alu_op); end
    if ({pc, retired} !== {8'd4, 16'd1}) begin miscompares++; $display("FAIL add_pc_ret: pc=%0d ret=%0d want 4/1", pc, retired); end
    exec_instr(rand_legal(1'b1), 5'($urandom), 1'b0);
  endtask

  task automatic test_sequence();
    do_reset();
    go();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) continue;
      exec_instr(mk_r(5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)), funct_tbl[i]),
                 5'($urandom), i != 7);
    end
    vectors++;
    if ({pc, retired} !== {8'd28, 16'd7}) begin miscompares++; $display("FAIL seq_pc_ret: pc=%0d ret=%0d want 28/7", pc, retired); end
  endtask

  task automatic test_rd_zero();
    go();
    exec_instr(mk_r(5'd3, 5'd4, 5'd0, 6'h22), 5'b10000, 1'b0);
    vectors++;
    if (flags !== 5'b10000) begin miscompares++; $display("FAIL rd0_flags: got %b want 10000", flags); end
  endtask

  task automatic test_run_drop();
    go();
    exec_instr(rand_legal(1'b0), 5'($urandom), 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({busy, pc} !== {1'b0, m_pc}) begin miscompares++; $display("FAIL idle_hold: busy=%b pc=%h want 0/%h", busy, pc, m_pc); end
    end
    go();
    exec_instr(rand_legal(1'b0), 5'($urandom), 1'b1);
    exec_instr(rand_legal(1'b1), 5'($urandom), 1'b0);
  endtask

  task automatic test_random();
    bit in_idle = 1'b1;
    bit ra;
    for (int n = 0; n < 90; n++) begin
      if (in_idle) go();
      ra = ($urandom_range(0, 3) != 0);
      exec_instr(rand_legal(1'b1), 5'($urandom), ra);
      in_idle = !ra;
      if (in_idle && $urandom_range(0, 1) == 1) tick();
    end
    if (!in_idle) begin
      exec_instr(rand_legal(1'b1), 5'($urandom), 1'b0);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2] = '{32'h8C000000, 32'h00000000};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      go();
      exec_instr(words[k], 5'($urandom), 1'b1);
      vectors++;
      if (pc !== 8'd4) begin miscompares++; $display("FAIL illegal_pc: got %0d want 4", pc); end
      for (int c = 0; c < 4; c++) begin
        tick();
        vectors++;
        if ({halted, busy, illegal, pc, retired, reg_we} !== {3'b101, m_pc, m_ret, 1'b0}) begin
          miscompares++; $display("FAIL halt_frozen: h/b/i=%b pc=%h ret=%0d we=%b", {halted, busy, illegal}, pc, retired, reg_we); end
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({pc, halted, illegal, busy} !== 11'd0) begin
        miscompares++; $display("FAIL halt_reset: pc=%h h/i/b=%b want 0", pc, {halted, illegal, busy}); end
      do_reset();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      go();
      exec_instr(rand_legal(1'b1), 5'b11111, 1'b1);
      inst = mk_r(5'd1, 5'd2, 5'd9, 6'h20);
      tick();
      tick();
      if (k == 1) tick();
      vectors++;
      if ({alu_op, flags, reg_we} !== {4'b0100, 5'b11111, k == 1}) begin
        miscompares++; $display("FAIL pre_reset: op=%b flags=%b we=%b", alu_op, flags, reg_we); end
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({pc, alu_op, flags, reg_we, busy} !== '0) begin
        miscompares++; $display("FAIL async_reset: pc=%h op=%b flags=%b we=%b busy=%b want 0", pc, alu_op, flags, reg_we, busy); end
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sequence();
    test_rd_zero();
    test_run_drop();
    test_random();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
